// File: rtl/game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl_pkg
// Purpose  : Shared constants and types for the Connect-4 event hub:
//            UART command bytes, button channel indices, win-sequencer
//            state encoding and a counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package game_ctrl_pkg;

  // UART command bytes
  localparam logic [7:0] CMD_LEFT  = 8'h01;
  localparam logic [7:0] CMD_RIGHT = 8'h02;
  localparam logic [7:0] CMD_DROP  = 8'h03;
  localparam logic [7:0] CMD_RESET = 8'h04;

  // Button channel assignment
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_DROP  = 2;
  localparam int BTN_RESET = 3;

  // Post-win delay sequencer
  typedef enum logic [0:0] {
    WIN_IDLE = 1'b0,
    WIN_HOLD = 1'b1
  } win_state_t;

  // Width of a counter that must reach n-1 (never zero bits wide)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_edge.sv
`default_nettype none
// ============================================================================
// Module   : debounce_edge
// Purpose  : One push-button channel. Synchronises an asynchronous
//            active-low button, debounces it with a stability counter and
//            emits a one-cycle pulse on each accepted press (1->0).
// Ports    : clk    - system clock
//            rstn   - synchronous active-low reset
//            btn_n  - raw active-low button, asynchronous
//            press  - registered one-cycle press pulse
// Revision : 1.0 - initial release
// ============================================================================
module debounce_edge
  import game_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_n,
  output logic press
);

  localparam int              CNT_W    = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      // cnt tracks consecutive samples that disagree with the accepted level;
      // any agreeing sample restarts the run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/game_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_event_ctrl
// Purpose  : Input/event hub for the Connect-4 top level. Merges debounced
//            buttons and UART command bytes into single-cycle game actions,
//            runs the per-turn timeout (automatic drop) and the post-win
//            delayed reset sequencer.
// Ports    : clk, rstn            - clock, synchronous active-low reset
//            btn_n[N_BTN]         - raw active-low buttons
//            rx_data, rx_valid    - UART byte and strobe
//            turn_active          - FSM waiting for a move (timer enable)
//            win_flag             - game-won level from FSM
//            move_left/right/drop - action pulses
//            times_up             - pulse with a timeout-only drop
//            game_reset           - reset pulse
//            btn_pulse[N_BTN]     - raw per-channel press pulses
//            turn_secs            - elapsed seconds in current turn
//            win_pending          - post-win delay running
// Revision : 1.0 - initial release
// ============================================================================
module game_event_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEB_CYCLES      = 250000,
  parameter int TICKS_PER_SEC   = 25000000,
  parameter int TURN_SECS       = 10,
  parameter int SEC_W           = 4,
  parameter int WIN_HOLD_CYCLES = 12500000
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_BTN-1:0] btn_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             turn_active,
  input  logic             win_flag,
  output logic             move_left,
  output logic             move_right,
  output logic             move_drop,
  output logic             times_up,
  output logic             game_reset,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [SEC_W-1:0] turn_secs,
  output logic             win_pending
);

  localparam int                TICK_W     = cnt_width(TICKS_PER_SEC);
  localparam int                WIN_W      = cnt_width(WIN_HOLD_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(WIN_HOLD_CYCLES - 1);
  localparam logic [SEC_W-1:0]  SECS_LIMIT = SEC_W'(TURN_SECS);
  localparam logic [SEC_W-1:0]  SECS_PREV  = SEC_W'(TURN_SECS - 1);

  // --------------------------------------------------------------------------
  // Button channels
  // --------------------------------------------------------------------------
  logic [N_BTN-1:0] press;

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      debounce_edge #(
        .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
        .clk   (clk),
        .rstn  (rstn),
        .btn_n (btn_n[i]),
        .press (press[i])
      );
    end
  endgenerate

  // Press pulses are already registered inside each channel.
  assign btn_pulse = press;

  // --------------------------------------------------------------------------
  // Request decode and action merge
  // --------------------------------------------------------------------------
  win_state_t        win_state;
  logic [WIN_W-1:0]  win_cnt;
  logic              win_prev;
  logic [TICK_W-1:0] tick;
  logic              timeout_req;

  logic [7:0] cmd;
  logic       req_reset;
  logic       ext_drop;
  logic       any_drop;
  logic       req_left;
  logic       req_right;
  logic       hold_end;
  logic       moves_ok;
  logic       reset_d;
  logic       drop_d;
  logic       times_up_d;
  logic       left_d;
  logic       right_d;

  always_comb begin
    cmd        = rx_valid ? rx_data : 8'h00;
    req_reset  = press[BTN_RESET] | (cmd == CMD_RESET);
    ext_drop   = press[BTN_DROP]  | (cmd == CMD_DROP);
    any_drop   = ext_drop | timeout_req;
    req_left   = press[BTN_LEFT]  | (cmd == CMD_LEFT);
    req_right  = press[BTN_RIGHT] | (cmd == CMD_RIGHT);
    hold_end   = (win_state == WIN_HOLD) && (win_cnt == WIN_LAST);
    // Moves are blocked by a reset in the same cycle and for the whole hold.
    moves_ok   = !req_reset && (win_state == WIN_IDLE);
    reset_d    = req_reset | hold_end;
    drop_d     = moves_ok & any_drop;
    times_up_d = drop_d & timeout_req & ~ext_drop;
    // A drop outranks lateral moves; opposing lateral requests cancel.
    left_d     = moves_ok & ~any_drop & req_left  & ~req_right;
    right_d    = moves_ok & ~any_drop & req_right & ~req_left;
  end

  // --------------------------------------------------------------------------
  // Win sequencer and registered action pulses
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      win_state   <= WIN_IDLE;
      win_cnt     <= '0;
      win_prev    <= 1'b0;
      win_pending <= 1'b0;
      move_left   <= 1'b0;
      move_right  <= 1'b0;
      move_drop   <= 1'b0;
      times_up    <= 1'b0;
      game_reset  <= 1'b0;
    end else begin
      win_prev   <= win_flag;
      move_left  <= left_d;
      move_right <= right_d;
      move_drop  <= drop_d;
      times_up   <= times_up_d;
      game_reset <= reset_d;
      case (win_state)
        WIN_IDLE: begin
          // A simultaneous manual reset wins over starting the hold.
          if (win_flag && !win_prev && !req_reset) begin
            win_state   <= WIN_HOLD;
            win_pending <= 1'b1;
            win_cnt     <= '0;
          end
        end
        WIN_HOLD: begin
          if (req_reset || hold_end) begin
            win_state   <= WIN_IDLE;
            win_pending <= 1'b0;
            win_cnt     <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        default: begin
          win_state   <= WIN_IDLE;
          win_pending <= 1'b0;
          win_cnt     <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Turn timer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tick        <= '0;
      turn_secs   <= '0;
      timeout_req <= 1'b0;
    end else begin
      timeout_req <= 1'b0;
      if (!turn_active || drop_d || reset_d) begin
        tick      <= '0;
        turn_secs <= '0;
      end else if (win_state == WIN_IDLE) begin
        if (tick == TICK_LAST) begin
          tick <= '0;
          // Saturate at the limit; the request fires only on the step onto it.
          if (turn_secs < SECS_LIMIT) begin
            turn_secs <= turn_secs + 1'b1;
            if (turn_secs == SECS_PREV) begin
              timeout_req <= 1'b1;
            end
          end
        end else begin
          tick <= tick + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/game_event_ctrl.md
Name: game_event_ctrl

Overview:
- Parametrised input/event hub for the Connect-4 top level. It merges N debounced push-buttons and UART command bytes into single-cycle game action pulses.
- It owns the per-turn timeout, which issues an automatic drop, and the post-win delayed reset sequencer.
- Sits between the raw KEY/UART receiver and connect4_fsm; replaces ad-hoc edge/timer logic in the top level.

Parameters:
- N_BTN, 4, number of button channels (min 4; ch0 left, ch1 right, ch2 drop, ch3 reset, rest generic)
- DEB_CYCLES, 250000, cycles a synchronised level must be stable before it is accepted
- TICKS_PER_SEC, 25000000, clk cycles per timer second
- TURN_SECS, 10, seconds per turn before an automatic drop
- SEC_W, 4, width of turn_secs (must hold TURN_SECS)
- WIN_HOLD_CYCLES, 12500000, cycles from win_flag rise to game_reset

Ports:
- clk  in  1  system clock (single domain)
- rstn  in  1  synchronous active-low reset
- btn_n  in  N_BTN  raw active-low buttons, asynchronous
- rx_data  in  8  UART byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- turn_active  in  1  FSM is waiting for a move; timer runs only when high
- win_flag  in  1  level from FSM, game won
- move_left  out  1  one-cycle pulse
- move_right  out  1  one-cycle pulse
- move_drop  out  1  one-cycle pulse
- times_up  out  1  one-cycle pulse, coincident with a timeout-caused move_drop
- game_reset  out  1  one-cycle pulse
- btn_pulse  out  N_BTN  raw per-channel press pulses, for debug or extra channels
- turn_secs  out  SEC_W  elapsed seconds in the current turn
- win_pending  out  1  high while the post-win delay runs

Behaviour:
- All outputs are registered. On rstn=0 at a clk edge:
  - every pulse output = 0, turn_secs = 0, win_pending = 0
  - debounced levels = 1 (released), tick counter = 0, win counter = 0
- Button path, per channel:
  - 2-FF synchroniser, then a stability counter. The debounced level updates only after DEB_CYCLES consecutive equal samples that differ from the current level.
  - Press = debounced 1->0. btn_pulse[i] goes high the cycle after the debounced level changes. Release produces no pulse.
- UART path: on rx_valid, decode in the same cycle; the action pulse appears next cycle.
  - 0x01 = left, 0x02 = right, 0x03 = drop, 0x04 = reset.
  - Any other byte is ignored.
- Action merge, evaluated per cycle (sources: button pulse, UART command, timeout). Priority, highest first:
  1. reset: game_reset=1; all move pulses suppressed.
  2. drop: move_drop=1, exactly once even if several sources fire. times_up=1 only if the timeout is the sole drop source.
  3. left/right: if both are requested in one cycle, neither is emitted.
- Turn timer:
  - Tick counter runs 0..TICKS_PER_SEC-1 while turn_active=1 and win_pending=0. On wrap, turn_secs increments.
  - When turn_secs becomes TURN_SECS: timeout request on that cycle; drop/times_up pulse the next cycle. turn_secs then holds at TURN_SECS with no second request.
  - Tick counter and turn_secs clear to 0 on any emitted move_drop, on game_reset, or while turn_active=0.
- Win sequencer, states IDLE -> HOLD -> IDLE:
  - IDLE->HOLD on win_flag rising edge (prev register). Win counter clears to 0; win_pending=1.
  - In HOLD: counter increments each cycle; move_left/right/drop/times_up are suppressed; the timer is frozen.
  - When counter == WIN_HOLD_CYCLES-1: game_reset pulse next cycle, return to IDLE.
  - Manual reset (button or UART) in HOLD: immediate game_reset, state -> IDLE, counter cleared.
  - win_flag held high after returning to IDLE does not retrigger; a new rising edge is required.
- btn_pulse is never suppressed.
- rstn=0 mid-operation aborts everything with no pulse emitted. rstn does not itself assert game_reset.

Decomposition:
- Package game_ctrl_pkg: UART command constants CMD_LEFT/RIGHT/DROP/RESET; button index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_DROP=2, BTN_RESET=3; win-sequencer state enum.
- Sub-module debounce_edge (one channel: sync, stability counter, press pulse; parameter DEB_CYCLES), instantiated N_BTN times via generate.

Test Plan (DEB_CYCLES=3, TICKS_PER_SEC=4, TURN_SECS=3, WIN_HOLD_CYCLES=8, N_BTN=4):
- btn_n[2] falls with 2-cycle glitches, then stays low for 10 cycles -> glitches produce nothing; exactly one move_drop and btn_pulse[2]; release produces no pulse.
- rx_valid with 0x01, then 0x02, then 0x7F -> move_left, then move_right (each the next cycle); 0x7F produces nothing.
- turn_active=1 for 12 cycles with no input -> turn_secs goes 1,2,3; one move_drop+times_up; turn_secs back to 0 afterwards.
- Timeout request cycle coincides with UART 0x03 -> a single move_drop, times_up=0.
- win_flag rises -> win_pending=1 for 8 cycles; a button left press during that time is suppressed; game_reset pulses once.
- Manual reset during HOLD, plus a left/right conflict in the same cycle as rx 0x04 -> immediate game_reset, no move pulses, win_pending=0.
